// File: rtl/button_arbiter_enabler.sv
// Press arbiter: sync/[debounce]/edge-detect per button, first eligible press per round wins (optional BTN_DEBOUNCE_EN filter).
// Latency: btn_raw to fire 4 edges, plus DEBOUNCE_CYC when BTN_DEBOUNCE_EN is defined.
// No backpressure: fire is a one-cycle pulse; presses after the grant only bump reject_cnt.
module button_arbiter_enabler #(
    parameter int                 NUM_BTN      = 2,
    parameter int                 COL_W        = 3,
    parameter int                 ROW_W        = 3,
    parameter int                 ROW_MAX      = 5,
    parameter logic [NUM_BTN-1:0] COORD_MASK   = 'b01,
    parameter int                 DEBOUNCE_CYC = 4,
    localparam int                IDX_W        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_en,
    input  logic [NUM_BTN-1:0] btn_allow,
    input  logic [COL_W-1:0]   col_sel,
    input  logic [ROW_W-1:0]   row_sel,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] fire,
    output logic               winner_vld,
    output logic [IDX_W-1:0]   winner_idx,
    output logic [7:0]         reject_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, LATCHED} state_t;

    localparam logic [ROW_W-1:0] ROW_MAX_L = ROW_W'(ROW_MAX);

    state_t             state_q, state_d;
    logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BTN-1:0] hist_q, hist_d, press_q, press_d;
    logic [NUM_BTN-1:0] fire_q, fire_d;
    logic               winner_vld_q, winner_vld_d;
    logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
    logic [7:0]         reject_cnt_q, reject_cnt_d;
    logic [NUM_BTN-1:0] filt;
    logic [NUM_BTN-1:0] elig, cand;
    logic               coord_ok;

`ifdef BTN_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYC - 1);

    logic [7:0]         db_cnt_q [NUM_BTN];
    logic [7:0]         db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] filt_q, filt_d;

    // Counter only runs while the synced level disagrees with the filtered one;
    // any agreement (a bounce back) restarts it from zero.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = 8'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= 8'd0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        hist_d  = filt;
        press_d = filt & ~hist_q;
    end

    assign coord_ok = (col_sel != '0) && (row_sel != '0) && (row_sel <= ROW_MAX_L);
    assign elig     = btn_allow & (~COORD_MASK | {NUM_BTN{coord_ok}});
    assign cand     = press_q & elig;

    always_comb begin
        state_d      = state_q;
        fire_d       = '0;
        winner_vld_d = winner_vld_q;
        winner_idx_d = winner_idx_q;
        reject_cnt_d = reject_cnt_q;
        if (!game_en) begin
            state_d      = IDLE;
            winner_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = ARMED;
                    reject_cnt_d = 8'd0;
                end
                ARMED: begin
                    if (|cand) begin
                        // Isolate the lowest set bit so only one button can fire.
                        fire_d       = cand & ~(cand - 1'b1);
                        winner_vld_d = 1'b1;
                        for (int i = NUM_BTN - 1; i >= 0; i--) begin
                            if (cand[i]) begin
                                winner_idx_d = IDX_W'(i);
                            end
                        end
                        state_d = LATCHED;
                    end
                end
                LATCHED: begin
                    if ((|press_q) && (reject_cnt_q != 8'hFF)) begin
                        reject_cnt_d = reject_cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            press_q      <= '0;
            fire_q       <= '0;
            winner_vld_q <= 1'b0;
            winner_idx_q <= '0;
            reject_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            press_q      <= press_d;
            fire_q       <= fire_d;
            winner_vld_q <= winner_vld_d;
            winner_idx_q <= winner_idx_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign fire       = fire_q;
    assign winner_vld = winner_vld_q;
    assign winner_idx = winner_idx_q;
    assign reject_cnt = reject_cnt_q;

endmodule

// File: doc/button_arbiter_enabler.md
# button_arbiter_enabler

Clocked, parametrised successor to the game's combinational button-enable logic. It takes up to NUM_BTN player buttons and grants exactly one accepted press per round; later presses are locked out until the round is re-armed. Each button's raw input is synchronised, optionally debounced and edge-detected. Eligibility depends on a per-button allow switch and, for masked buttons, a valid letter/number coordinate from the switch bank. It sits between the board switches and buttons and the game-status and display logic.

## Interface
Parameters:
- NUM_BTN, 2: number of buttons (2..8).
- COL_W, 3: width of the letter coordinate field.
- ROW_W, 3: width of the number coordinate field.
- ROW_MAX, 5: highest valid row code; the valid rows are 1..ROW_MAX.
- COORD_MASK, 'b01: bit i set means button i requires a valid coordinate.
- DEBOUNCE_CYC, 4: number of stable cycles required by the debounce filter (1..255).

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- game_en, input, 1: round enable. Quasi-static switch, used unsynchronised.
- btn_allow, input, NUM_BTN: per-button enable switch. Quasi-static.
- col_sel, input, COL_W: letter coordinate. Valid when nonzero.
- row_sel, input, ROW_W: number coordinate. Valid when 1 ≤ row_sel ≤ ROW_MAX.
- btn_raw, input, NUM_BTN: asynchronous raw buttons, active-high.
- fire, output, NUM_BTN: one-cycle pulse on the granted button.
- winner_vld, output, 1: a press has been granted in this round.
- winner_idx, output, $clog2(NUM_BTN) (minimum 1): index of the granted button.
- reject_cnt, output, 8: saturating count of presses ignored while LATCHED.

## Operation
- Per button input path: a 2-FF synchroniser, then an optional debounce filter, then a registered rising-edge detector that produces press[i].
- coord_ok = (col_sel != 0) && (row_sel >= 1) && (row_sel <= ROW_MAX).
- elig[i] = btn_allow[i] && (!COORD_MASK[i] || coord_ok).
- The FSM has three states: IDLE, ARMED and LATCHED.
  - IDLE: the FSM enters ARMED when game_en = 1. Entering ARMED clears reject_cnt.
  - ARMED: if any press[i] && elig[i], the FSM grants the lowest such index. It pulses fire[i], sets winner_vld = 1, loads winner_idx = i and moves to LATCHED. A press on an ineligible button is dropped and is not counted.
  - LATCHED: every press[i] increments reject_cnt, saturating at 255. Multiple simultaneous presses add 1 in total, not one per button. fire stays 0.
  - From any state, game_en = 0 forces IDLE at the next edge and clears winner_vld. winner_idx holds its last value.
- Priority: game_en = 0 overrides a grant in the same cycle, so there is no fire and no state change other than the move to IDLE.
- When several buttons are simultaneously eligible, the lowest index wins. Only one fire bit is ever set.
- Edge detector history is updated in every state. A button already held high when ARMED is entered does not fire until it is released and pressed again.

## Timing
- Reset values: fire = 0, winner_vld = 0, winner_idx = 0, reject_cnt = 0, FSM = IDLE. All synchroniser, filter and edge-history flops are 0.
- Asserting rst_n mid-round clears all state immediately. Reset is released synchronously through the flops.
- IDLE→ARMED takes one edge after game_en is seen high.
- Press latency (debounce compiled out): if btn_raw rises before clock edge E0, fire is high during the cycle after edge E0+3. The edge at E0+3 is the fourth edge counting E0.
- Press latency (debounce compiled in): DEBOUNCE_CYC extra cycles, so fire is high after edge E0+3+DEBOUNCE_CYC.
- fire lasts exactly one cycle. winner_vld and winner_idx update on the same edge as fire.
- reject_cnt updates on the edge at which fire would otherwise have asserted.

## Configuration
- BTN_DEBOUNCE_EN defined:
  - Each button has an 8-bit stability counter.
  - The filtered level takes the synchronised value only after that value has differed from the current filtered level for DEBOUNCE_CYC consecutive cycles.
  - Any bounce restarts the count.
- BTN_DEBOUNCE_EN undefined:
  - The filtered level equals the synchroniser output.
  - No counters are instantiated.
  - DEBOUNCE_CYC is ignored.

## Test plan
- Reset and basic grant: hold rst_n = 0, then release. Check all outputs are 0. With game_en = 1, btn_allow = 2'b11, col = 1, row = 3, pulse btn_raw[1] → fire = 2'b10 for 1 cycle at the specified latency, winner_vld = 1, winner_idx = 1.
- Coordinate gating: with row_sel = 6, press btn 0 → no fire and reject_cnt = 0. Set row_sel = 5 and press again → fire[0].
- Simultaneous press: raise btn_raw = 2'b11 on the same edge → fire = 2'b01 and winner_idx = 0. Then deliver 300 separate presses → reject_cnt = 255.
- Re-arm: drop game_en → winner_vld = 0 the next cycle. Raise game_en while btn 1 is still held → no fire. Release and press btn 1 again → fire[1] and reject_cnt = 0.
- Override: drop game_en on the same edge a grant would occur → no fire, and the FSM is in IDLE.
- Debounce (BTN_DEBOUNCE_EN, DEBOUNCE_CYC = 4): a 3-cycle glitch produces no fire. A 10-cycle press produces fire exactly once, after edge E0+7. Repeat with the macro undefined: the glitch fires.
